// File: rtl/msrv32_decode_stage.sv
// RV32I(+M) decode stage: registered control bundle behind a 1- or 2-entry output buffer, with legality checks and illegal count.
// Latency 1 cycle; with BUF_DEPTH=2 instr_ready_out depends only on skid occupancy, so one instruction per cycle survives backpressure.
module msrv32_decode_stage #(
    parameter int M_EXT     = 0,
    parameter int BUF_DEPTH = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic                 flush_in,
    input  logic                 instr_valid_in,
    output logic                 instr_ready_out,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          instr_in,
    output logic                 dec_valid_out,
    input  logic                 dec_ready_in,
    output logic [31:0]          pc_out,
    output logic [31:0]          instr_out,
    output logic [4:0]           rs1_addr_out,
    output logic [4:0]           rs2_addr_out,
    output logic [4:0]           rd_addr_out,
    output logic [2:0]           imm_type_out,
    output logic [4:0]           alu_opcode_out,
    output logic                 alu_src_out,
    output logic [2:0]           wb_mux_sel_out,
    output logic [1:0]           load_size_out,
    output logic                 load_unsigned_out,
    output logic                 mem_wr_req_out,
    output logic [2:0]           csr_op_out,
    output logic                 csr_wr_en_out,
    output logic                 rf_wr_en_out,
    output logic                 illegal_instr_out,
    output logic [ILL_CNT_W-1:0] ill_count_out
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  imm_type;
        logic [4:0]  alu_opcode;
        logic        alu_src;
        logic [2:0]  wb_mux_sel;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic        mem_wr_req;
        logic [2:0]  csr_op;
        logic        csr_wr_en;
        logic        rf_wr_en;
        logic        illegal;
    } dec_t;

    dec_t                 dec_d;
    dec_t                 out_q, out_d;
    dec_t                 skid_q, skid_d;
    logic                 out_vld_q, out_vld_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 accept;
    logic                 deliver;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    always_comb begin
        dec_d                  = '0;
        dec_d.pc               = pc_in;
        dec_d.instr            = instr_in;
        dec_d.alu_opcode[2:0]  = funct3;
        // Full 7-bit match, so any word with instr[1:0] != 11 lands in default.
        case (opcode)
            OPC_LUI: begin
                dec_d.imm_type   = 3'b100;
                dec_d.wb_mux_sel = 3'b010;
                dec_d.rf_wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.imm_type   = 3'b100;
                dec_d.wb_mux_sel = 3'b011;
                dec_d.rf_wr_en   = 1'b1;
            end
            OPC_JAL: begin
                dec_d.imm_type   = 3'b101;
                dec_d.wb_mux_sel = 3'b101;
                dec_d.rf_wr_en   = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm_type   = 3'b001;
                dec_d.wb_mux_sel = 3'b101;
                dec_d.rf_wr_en   = 1'b1;
                dec_d.illegal    = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_d.imm_type = 3'b011;
                dec_d.illegal  = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec_d.imm_type      = 3'b001;
                dec_d.wb_mux_sel    = 3'b001;
                dec_d.load_size     = funct3[1:0];
                dec_d.load_unsigned = funct3[2];
                dec_d.rf_wr_en      = 1'b1;
                dec_d.illegal       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_d.imm_type   = 3'b010;
                dec_d.mem_wr_req = 1'b1;
                dec_d.illegal    = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_d.imm_type = 3'b001;
                dec_d.rf_wr_en = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_d.illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_d.alu_opcode[3] = funct7[5];
                    dec_d.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                dec_d.alu_src  = 1'b1;
                dec_d.rf_wr_en = 1'b1;
                if (funct7 == 7'b0000001 && M_EXT != 0) begin
                    dec_d.alu_opcode[4] = 1'b1;
                end else begin
                    dec_d.alu_opcode[3] = funct7[5];
                    if (funct7 == 7'b0100000) begin
                        dec_d.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end else begin
                        dec_d.illegal = (funct7 != 7'b0000000);
                    end
                end
            end
            OPC_MISC_MEM: begin
                dec_d.illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                dec_d.csr_op  = funct3;
                dec_d.illegal = (funct3 == 3'b100);
                if (funct3 != 3'b000) begin
                    dec_d.imm_type   = funct3[2] ? 3'b110 : 3'b001;
                    dec_d.wb_mux_sel = 3'b100;
                    dec_d.csr_wr_en  = 1'b1;
                    dec_d.rf_wr_en   = 1'b1;
                end
            end
            default: begin
                dec_d.illegal = 1'b1;
            end
        endcase
        if (dec_d.illegal) begin
            dec_d.rf_wr_en   = 1'b0;
            dec_d.csr_wr_en  = 1'b0;
            dec_d.mem_wr_req = 1'b0;
        end
    end

    assign instr_ready_out = (BUF_DEPTH == 1) ? (~out_vld_q | dec_ready_in) : ~skid_vld_q;
    assign accept          = instr_valid_in & instr_ready_out;
    assign deliver         = out_vld_q & dec_ready_in & ~flush_in;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        ill_cnt_d  = ill_cnt_q;
        if (deliver && out_q.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
        if (flush_in) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || dec_ready_in) begin
            // Skid holds the older beat; instr_ready_out was low, so no accept competes with it.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_d = dec_d;
                end
            end
        end else if (accept) begin
            skid_d     = dec_d;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            ill_cnt_q  <= '0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign dec_valid_out     = out_vld_q;
    assign pc_out            = out_q.pc;
    assign instr_out         = out_q.instr;
    assign rs1_addr_out      = out_q.instr[19:15];
    assign rs2_addr_out      = out_q.instr[24:20];
    assign rd_addr_out       = out_q.instr[11:7];
    assign imm_type_out      = out_q.imm_type;
    assign alu_opcode_out    = out_q.alu_opcode;
    assign alu_src_out       = out_q.alu_src;
    assign wb_mux_sel_out    = out_q.wb_mux_sel;
    assign load_size_out     = out_q.load_size;
    assign load_unsigned_out = out_q.load_unsigned;
    assign mem_wr_req_out    = out_q.mem_wr_req;
    assign csr_op_out        = out_q.csr_op;
    assign csr_wr_en_out     = out_q.csr_wr_en;
    assign rf_wr_en_out      = out_q.rf_wr_en;
    assign illegal_instr_out = out_q.illegal;
    assign ill_count_out     = ill_cnt_q;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Two decode stages share one stimulus stream: dut0 (RV32I, 2-bit counter) and dut1 (RV32IM, 8-bit counter).
module tb_msrv32_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush_in, instr_valid_in, dec_ready_in;
    logic [31:0] pc_in, instr_in;

    logic        rdy0, vld0, src0, lu0, mw0, cw0, rw0, il0;
    logic [31:0] pc0, ins0;
    logic [4:0]  rs1_0, rs2_0, rd0, aop0;
    logic [2:0]  imm0, wb0, cop0;
    logic [1:0]  lsz0, cnt0;
    logic        rdy1, vld1, src1, lu1, mw1, cw1, rw1, il1;
    logic [31:0] pc1, ins1;
    logic [4:0]  rs1_1, rs2_1, rd1, aop1;
    logic [2:0]  imm1, wb1, cop1;
    logic [1:0]  lsz1;
    logic [7:0]  cnt1;

    logic [21:0] ctrl0, ctrl1;
    assign ctrl0 = {imm0, aop0, src0, wb0, lsz0, lu0, mw0, cop0, cw0, rw0, il0};
    assign ctrl1 = {imm1, aop1, src1, wb1, lsz1, lu1, mw1, cop1, cw1, rw1, il1};

    msrv32_decode_stage #(.M_EXT(0), .BUF_DEPTH(2), .ILL_CNT_W(2)) dut0 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(rdy0), .pc_in(pc_in), .instr_in(instr_in),
        .dec_valid_out(vld0), .dec_ready_in(dec_ready_in), .pc_out(pc0), .instr_out(ins0),
        .rs1_addr_out(rs1_0), .rs2_addr_out(rs2_0), .rd_addr_out(rd0), .imm_type_out(imm0),
        .alu_opcode_out(aop0), .alu_src_out(src0), .wb_mux_sel_out(wb0), .load_size_out(lsz0),
        .load_unsigned_out(lu0), .mem_wr_req_out(mw0), .csr_op_out(cop0), .csr_wr_en_out(cw0),
        .rf_wr_en_out(rw0), .illegal_instr_out(il0), .ill_count_out(cnt0));

    msrv32_decode_stage #(.M_EXT(1), .BUF_DEPTH(2), .ILL_CNT_W(8)) dut1 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(rdy1), .pc_in(pc_in), .instr_in(instr_in),
        .dec_valid_out(vld1), .dec_ready_in(dec_ready_in), .pc_out(pc1), .instr_out(ins1),
        .rs1_addr_out(rs1_1), .rs2_addr_out(rs2_1), .rd_addr_out(rd1), .imm_type_out(imm1),
        .alu_opcode_out(aop1), .alu_src_out(src1), .wb_mux_sel_out(wb1), .load_size_out(lsz1),
        .load_unsigned_out(lu1), .mem_wr_req_out(mw1), .csr_op_out(cop1), .csr_wr_en_out(cw1),
        .rf_wr_en_out(rw1), .illegal_instr_out(il1), .ill_count_out(cnt1));

    typedef struct {
        logic [31:0] instr;
        logic [21:0] c0;
        logic [21:0] c1;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [21:0] c0;
        logic [21:0] c1;
    } exp_t;

    vec_t        vecs[18];
    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          exp_cnt0 = 0;
    int          exp_cnt1 = 0;
    int          cyc = 0;
    logic [31:0] next_pc = 32'h0000_1000;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic add(input int i, input logic [31:0] ins, input logic [2:0] imm, input logic [4:0] aop,
                       input logic src, input logic [2:0] wb, input logic [1:0] lsz, input logic lu,
                       input logic mw, input logic [2:0] cop, input logic cw, input logic rw, input logic il,
                       input logic [4:0] aop_m, input logic rw_m, input logic il_m);
        vecs[i].instr = ins;
        vecs[i].c0    = {imm, aop, src, wb, lsz, lu, mw, cop, cw, rw, il};
        vecs[i].c1    = {imm, aop_m, src, wb, lsz, lu, mw, cop, cw, rw_m, il_m};
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send(input int idx);
        bit ok = 0;
        bit acc;
        instr_valid_in = 1'b1;
        pc_in          = next_pc;
        instr_in       = vecs[idx].instr;
        for (int c = 0; c < 50 && !ok; c++) begin
            acc = rdy0;
            @(posedge clk);
            if (acc) begin
                q.push_back('{pc: next_pc, instr: vecs[idx].instr, c0: vecs[idx].c0, c1: vecs[idx].c1});
                ok = 1;
            end
            #1;
        end
        instr_valid_in = 1'b0;
        next_pc        = next_pc + 32'd4;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: vector %0d not accepted within 50 cycles", idx);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && q.size() > 0; c++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d bundles still pending, want 0", q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !flush_in && dec_ready_in && vld0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: got pc %0h, want no bundle", pc0);
            end else begin
                mon_e = q.pop_front();
                chk("pc0", pc0, mon_e.pc);
                chk("instr0", ins0, mon_e.instr);
                chk("rd0", rd0, mon_e.instr[11:7]);
                chk("rs1_0", rs1_0, mon_e.instr[19:15]);
                chk("rs2_0", rs2_0, mon_e.instr[24:20]);
                chk("ctrl0", ctrl0, mon_e.c0);
                chk("valid1", vld1, 1);
                chk("pc1", pc1, mon_e.pc);
                chk("ctrl1", ctrl1, mon_e.c1);
                chk("ill_cnt0", cnt0, exp_cnt0);
                chk("ill_cnt1", cnt1, exp_cnt1);
                if (mon_e.c0[0] && exp_cnt0 != 3) exp_cnt0++;
                if (mon_e.c1[0] && exp_cnt1 != 255) exp_cnt1++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_a;
        int          t0;
        rst = 1'b1; flush_in = 1'b0; instr_valid_in = 1'b0; dec_ready_in = 1'b1;
        pc_in = '0; instr_in = '0;
        //       instr         imm     aluop     src  wb      lsz    lu mw cop    cw rw il   aluop(M)  rw il
        add(0,  32'h00500093, 3'b001, 5'b00000, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b00000, 1, 0);
        add(1,  32'h00108113, 3'b001, 5'b00000, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b00000, 1, 0);
        add(2,  32'h40208033, 3'b000, 5'b01000, 1, 3'b000, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b01000, 1, 0);
        add(3,  32'h02208033, 3'b000, 5'b00000, 1, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b10000, 1, 0);
        add(4,  32'h0000B083, 3'b001, 5'b00011, 0, 3'b001, 2'b11, 0, 0, 3'b000, 0, 0, 1, 5'b00011, 0, 1);
        add(5,  32'h0000C083, 3'b001, 5'b00100, 0, 3'b001, 2'b00, 1, 0, 3'b000, 0, 1, 0, 5'b00100, 1, 0);
        add(6,  32'h0000007C, 3'b000, 5'b00000, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b00000, 0, 1);
        add(7,  32'h000090E7, 3'b001, 5'b00001, 0, 3'b101, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b00001, 0, 1);
        add(8,  32'h008000EF, 3'b101, 5'b00000, 0, 3'b101, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b00000, 1, 0);
        add(9,  32'h123452B7, 3'b100, 5'b00101, 0, 3'b010, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b00101, 1, 0);
        add(10, 32'h00000197, 3'b100, 5'b00000, 0, 3'b011, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b00000, 1, 0);
        add(11, 32'h0020A223, 3'b010, 5'b00010, 0, 3'b000, 2'b00, 0, 1, 3'b000, 0, 0, 0, 5'b00010, 0, 0);
        add(12, 32'h0020B223, 3'b010, 5'b00011, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b00011, 0, 1);
        add(13, 32'h00208463, 3'b011, 5'b00000, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 0, 5'b00000, 0, 0);
        add(14, 32'h0020A463, 3'b011, 5'b00010, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b00010, 0, 1);
        add(15, 32'h4030D093, 3'b001, 5'b01101, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 1, 0, 5'b01101, 1, 0);
        add(16, 32'h40009093, 3'b001, 5'b00001, 0, 3'b000, 2'b00, 0, 0, 3'b000, 0, 0, 1, 5'b00001, 0, 1);
        add(17, 32'h3002D0F3, 3'b110, 5'b00101, 0, 3'b100, 2'b00, 0, 0, 3'b101, 1, 1, 0, 5'b00101, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid0", vld0, 0);
        chk("reset_ready0", rdy0, 1);
        chk("reset_cnt0", cnt0, 0);
        chk("reset_pc0", pc0, 0);
        chk("reset_ctrl0", ctrl0, 0);
        chk("reset_valid1", vld1, 0);
        chk("reset_ready1", rdy1, 1);

        // Full-rate stream through every decode vector.
        t0 = cyc;
        for (int i = 0; i < 18; i++) send(i);
        chk("stream_cycles", cyc - t0, 18);
        drain();
        chk("sat_cnt0", cnt0, 3);
        chk("cnt1_after_stream", cnt1, 6);

        // Backpressure: output + skid fill, third beat waits.
        dec_ready_in = 1'b0;
        pc_a = next_pc;
        fork
            begin
                send(0); send(2); send(5);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_ready0", rdy0, 0);
                chk("stall_hold_pc0", pc0, pc_a);
                chk("stall_valid0", vld0, 1);
                dec_ready_in = 1'b1;
            end
        join
        drain();

        // Flush with both entries full and a new beat offered.
        dec_ready_in = 1'b0;
        send(3); send(4);
        chk("pre_flush_ready0", rdy0, 0);
        instr_valid_in = 1'b1;
        instr_in       = vecs[0].instr;
        pc_in          = next_pc;
        flush_in       = 1'b1;
        @(posedge clk);
        #1;
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        q.delete();
        chk("flush_valid0", vld0, 0);
        chk("flush_ready0", rdy0, 1);
        chk("flush_valid1", vld1, 0);
        dec_ready_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_output0", vld0, 0);
        chk("flush_keeps_cnt0", cnt0, 3);

        // Synchronous reset while stalled with skid full.
        dec_ready_in = 1'b0;
        send(1); send(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        chk("rst2_valid0", vld0, 0);
        chk("rst2_ready0", rdy0, 1);
        chk("rst2_cnt0", cnt0, 0);
        chk("rst2_cnt1", cnt1, 0);
        chk("rst2_instr0", ins0, 0);
        chk("rst2_ctrl0", ctrl0, 0);

        dec_ready_in = 1'b1;
        send(4); send(6); send(0);
        drain();
        chk("final_cnt0", cnt0, 2);
        chk("final_cnt1", cnt1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
